// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions: CCITT-FALSE defaults, engine state type and the
// single-bit LFSR update used by every datapath stage.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY_CCITT = 16'h1021;
  localparam logic [15:0] CRC16_INIT_CCITT = 16'hFFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } crc16_state_e;

  // One message bit into an MSB-first CRC register; x^16 term is implicit.
  function automatic logic [15:0] crc16_bit_step(
    input logic [15:0] crc,
    input logic        bit_in,
    input logic [15:0] poly
  );
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_step.sv
// Combinational BPC-bit CRC update: a chain of single-bit steps, first message
// bit at the head of the chain.
module crc16_step
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY       = CRC16_POLY_CCITT,
  parameter int          BPC        = 1,
  parameter bit          REFLECT_IN = 1'b0
) (
  input  logic [15:0]    crc_in,
  input  logic [BPC-1:0] bits,
  output logic [15:0]    crc_next
);

  logic [BPC:0][15:0] chain;

  assign chain[0] = crc_in;

  // MSB-first takes bits[BPC-1] first; LSB-first takes bits[0] first.
  for (genvar i = 0; i < BPC; i++) begin : g_bit
    localparam int IDX = REFLECT_IN ? i : (BPC - 1 - i);
    assign chain[i+1] = crc16_bit_step(chain[i], bits[IDX], POLY);
  end

  assign crc_next = chain[BPC];

endmodule

// File: rtl/crc16_engine.sv
// Serial CRC-16 engine: absorbs one strobed byte at BPC bits per clock and
// exposes the running CRC with busy/done handshake for the upstream writer.
module crc16_engine
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY       = CRC16_POLY_CCITT,
  parameter logic [15:0] INIT_VAL   = CRC16_INIT_CCITT,
  parameter int          BPC        = 1,
  parameter bit          REFLECT_IN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic [7:0]  data,
  input  logic        data_valid,
  output logic [15:0] crc_out,
  output logic        busy,
  output logic        done
);

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8)) begin : g_bpc_check
    $error("crc16_engine: BPC must be 1, 2, 4 or 8");
  end

  localparam int          N_STEPS  = (BPC > 0) ? (8 / BPC) : 1;
  localparam logic [2:0]  CNT_LOAD = 3'(N_STEPS - 1);

  crc16_state_e state, state_nxt;
  logic [2:0]   cnt, cnt_nxt;
  logic [7:0]   shreg, shreg_nxt;
  logic [15:0]  crc_q, crc_nxt;
  logic         done_q, done_nxt;

  logic [BPC-1:0] step_bits;
  logic [15:0]    step_crc;

  // Present the next BPC message bits in the order the step chain expects.
  if (REFLECT_IN) begin : g_lsb_first
    assign step_bits = shreg[BPC-1:0];
  end else begin : g_msb_first
    assign step_bits = shreg[7 -: BPC];
  end

  crc16_step #(
    .POLY       (POLY),
    .BPC        (BPC),
    .REFLECT_IN (REFLECT_IN)
  ) u_step (
    .crc_in   (crc_q),
    .bits     (step_bits),
    .crc_next (step_crc)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    crc_nxt   = crc_q;
    done_nxt  = 1'b0;
    if (init) begin
      // init overrides everything, including a strobe in the same cycle.
      state_nxt = IDLE;
      cnt_nxt   = 3'd0;
      shreg_nxt = 8'h00;
      crc_nxt   = INIT_VAL;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            shreg_nxt = data;
            cnt_nxt   = CNT_LOAD;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          crc_nxt   = step_crc;
          shreg_nxt = REFLECT_IN ? (shreg >> BPC) : (shreg << BPC);
          if (cnt == 3'd0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      shreg  <= 8'h00;
      crc_q  <= INIT_VAL;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      shreg  <= shreg_nxt;
      crc_q  <= crc_nxt;
      done_q <= done_nxt;
    end
  end

  assign crc_out = crc_q;
  assign busy    = (state == SHIFT);
  assign done    = done_q;

endmodule

// File: tb/tb_crc16_engine.sv
// Bench for crc16_engine: four instances (BPC=1,2,4,8) checked every cycle
// against a byte-level CRC model plus hand-computed CCITT-FALSE results.
module tb_crc16_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_v [4];
  logic        dv_v   [4];
  logic [7:0]  data_v [4];
  logic [15:0] crc_v  [4];
  logic        busy_v [4];
  logic        done_v [4];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    crc16_engine #(.BPC(1 << k)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init       (init_v[k]),
      .data       (data_v[k]),
      .data_valid (dv_v[k]),
      .crc_out    (crc_v[k]),
      .busy       (busy_v[k]),
      .done       (done_v[k])
    );
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          m_left   [4];
  logic [15:0] m_crc    [4];
  logic [15:0] m_pend   [4];
  logic        m_done   [4];
  int          done_cnt [4];
  int          busy_cyc [4];

  // Byte-at-a-time CCITT: XOR the byte into the top, then eight shifts.
  function automatic logic [15:0] model_crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_left[k] = 0;
      m_crc[k]  = 16'hFFFF;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      if (!rst_n || init_v[k]) begin
        m_left[k] = 0;
        m_crc[k]  = 16'hFFFF;
        m_done[k] = 1'b0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        m_done[k] = (m_left[k] == 0);
        if (m_left[k] == 0) m_crc[k] = m_pend[k];
      end else begin
        m_done[k] = 1'b0;
        if (dv_v[k]) begin
          m_pend[k] = model_crc_byte(m_crc[k], data_v[k]);
          m_left[k] = 8 >> k;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("busy%0d@%0d", k, cyc), 32'(busy_v[k]), 32'(m_left[k] > 0));
      chk($sformatf("done%0d@%0d", k, cyc), 32'(done_v[k]), 32'(m_done[k]));
      if (m_left[k] == 0)
        chk($sformatf("crc%0d@%0d", k, cyc), 32'(crc_v[k]), 32'(m_crc[k]));
      if (busy_v[k]) busy_cyc[k]++;
      if (done_v[k]) done_cnt[k]++;
    end
  endtask

  task automatic pulse_init(input int k);
    init_v[k] = 1'b1;
    tick();
    init_v[k] = 1'b0;
    done_cnt[k] = 0;
    busy_cyc[k] = 0;
  endtask

  task automatic issue(input int k, input logic [7:0] b);
    dv_v[k]   = 1'b1;
    data_v[k] = b;
    tick();
    dv_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    while (!done_v[k] && t < 20) begin
      tick();
      t++;
    end
    if (!done_v[k]) fail_timeout($sformatf("wait_done%0d", k));
  endtask

  task automatic run_vector(input int k);
    int start;
    pulse_init(k);
    start = cyc;
    for (int i = 0; i < 9; i++) begin
      issue(k, 8'h31 + 8'(i));
      wait_done(k);
    end
    chk($sformatf("vec_cycles%0d", k), 32'(cyc - start), 32'(9 * ((8 >> k) + 1)));
    tick();
    chk($sformatf("vec_crc%0d", k), 32'(crc_v[k]), 32'h29B1);
    chk($sformatf("vec_done%0d", k), 32'(done_cnt[k]), 32'd9);
    chk($sformatf("vec_busy%0d", k), 32'(busy_cyc[k]), 32'(9 * (8 >> k)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mc;
    for (int k = 0; k < 4; k++) begin
      init_v[k] = 1'b0;
      dv_v[k]   = 1'b0;
      data_v[k] = 8'h00;
      done_cnt[k] = 0;
      busy_cyc[k] = 0;
    end
    model_reset();

    // Model pinned against known CCITT-FALSE results.
    chk("model_A", 32'(model_crc_byte(16'hFFFF, 8'h41)), 32'hB915);
    mc = 16'hFFFF;
    for (int i = 0; i < 9; i++) mc = model_crc_byte(mc, 8'h31 + 8'(i));
    chk("model_123456789", 32'(mc), 32'h29B1);

    // Reset state.
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_crc%0d", k), 32'(crc_v[k]), 32'hFFFF);
      chk($sformatf("rst_busy%0d", k), 32'(busy_v[k]), 32'd0);
      chk($sformatf("rst_done%0d", k), 32'(done_v[k]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Init pulse alone.
    pulse_init(0);
    repeat (3) tick();
    chk("init_crc", 32'(crc_v[0]), 32'hFFFF);
    chk("init_done", 32'(done_cnt[0]), 32'd0);

    // Single byte 'A' at BPC=1.
    pulse_init(0);
    issue(0, 8'h41);
    wait_done(0);
    tick();
    chk("A_busy_cycles", 32'(busy_cyc[0]), 32'd8);
    chk("A_done", 32'(done_cnt[0]), 32'd1);
    chk("A_crc", 32'(crc_v[0]), 32'hB915);

    // Check string, back-to-back on the done cycle, every BPC.
    for (int k = 0; k < 4; k++) run_vector(k);

    // Strobes while busy are ignored.
    pulse_init(0);
    issue(0, 8'h41);
    tick();
    dv_v[0] = 1'b1; data_v[0] = 8'hFF;
    tick();
    dv_v[0] = 1'b0;
    tick();
    tick();
    dv_v[0] = 1'b1; data_v[0] = 8'h00;
    tick();
    dv_v[0] = 1'b0;
    wait_done(0);
    tick();
    tick();
    chk("ignore_crc", 32'(crc_v[0]), 32'hB915);
    chk("ignore_done", 32'(done_cnt[0]), 32'd1);

    // Init on the 4th SHIFT cycle aborts the byte.
    pulse_init(0);
    issue(0, 8'h41);
    tick();
    tick();
    tick();
    init_v[0] = 1'b1;
    tick();
    init_v[0] = 1'b0;
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_crc", 32'(crc_v[0]), 32'hFFFF);
    repeat (10) tick();
    chk("abort_done", 32'(done_cnt[0]), 32'd0);

    // Init and strobe together: byte dropped.
    busy_cyc[0] = 0;
    init_v[0] = 1'b1; dv_v[0] = 1'b1; data_v[0] = 8'h41;
    tick();
    init_v[0] = 1'b0; dv_v[0] = 1'b0;
    chk("initdv_busy", 32'(busy_v[0]), 32'd0);
    chk("initdv_crc", 32'(crc_v[0]), 32'hFFFF);
    repeat (10) tick();
    chk("initdv_busy_cycles", 32'(busy_cyc[0]), 32'd0);

    // Async reset mid-SHIFT, observed before any clock edge.
    pulse_init(1);
    issue(1, 8'h41);
    tick();
    chk("pre_rst_busy", 32'(busy_v[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("arst_crc%0d", k), 32'(crc_v[k]), 32'hFFFF);
      chk($sformatf("arst_busy%0d", k), 32'(busy_v[k]), 32'd0);
      chk($sformatf("arst_done%0d", k), 32'(done_v[k]), 32'd0);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
    done_cnt[1] = 0;
    issue(1, 8'h41);
    wait_done(1);
    tick();
    chk("post_rst_crc", 32'(crc_v[1]), 32'hB915);
    chk("post_rst_done", 32'(done_cnt[1]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
